// File: rtl/cache_fill_ctrl_if.sv
// Pipelined main-memory port shared by the I/D fill controller (master) and memory (slave).
interface cache_fill_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              mem_enable;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_data_valid;

  modport master (
    output mem_enable, mem_wr, mem_addr, mem_data_out,
    input  mem_data_in, mem_data_valid
  );

  modport slave (
    input  mem_enable, mem_wr, mem_addr, mem_data_out,
    output mem_data_in, mem_data_valid
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Miss/fill controller: arbitrates D stores, D load misses and I misses onto the
// shared pipelined memory, streams block fills into the caches and writes tags.
module cache_fill_ctrl #(
  parameter  int unsigned WORDS   = 8,
  parameter  int unsigned MEM_LAT = 4,
  parameter  int unsigned ADDR_W  = 16,
  localparam int unsigned DATA_W  = 16,
  localparam int unsigned IDX_W   = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss_i,
  input  logic [ADDR_W-1:0] i_miss_addr_i,
  input  logic              d_miss_i,
  input  logic [ADDR_W-1:0] d_miss_addr_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_wr_addr_i,
  input  logic [DATA_W-1:0] d_wr_data_i,
  cache_fill_ctrl_if.master mem,
  output logic              i_fill_we_o,
  output logic              d_fill_we_o,
  output logic [IDX_W-1:0]  fill_word_idx_o,
  output logic [DATA_W-1:0] fill_data_o,
  output logic [ADDR_W-1:0] fill_blk_addr_o,
  output logic              i_tag_we_o,
  output logic              d_tag_we_o,
  output logic              i_stall_o,
  output logic              d_stall_o
);

  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * WORDS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_REQ,
    S_DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    req_cnt_q, req_cnt_d;
  logic [IDX_W-1:0]    rx_cnt_q, rx_cnt_d;
  logic [ADDR_W-1:0]   blk_q, blk_d;
  logic                tgt_i_q, tgt_i_d;
  logic [MEM_LAT-1:0]  rd_pipe_q, rd_pipe_d;

  logic rd_issue_c;
  logic accept_c;
  logic last_c;
  logic dispatch_c;
  logic d_miss_ok_c;
  logic i_miss_ok_c;

  // State register; the read pipe remembers which cycles issued reads for the
  // current fill, so responses to reads orphaned by a reset are never accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      req_cnt_q <= '0;
      rx_cnt_q  <= '0;
      blk_q     <= '0;
      tgt_i_q   <= 1'b0;
      rd_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      blk_q     <= blk_d;
      tgt_i_q   <= tgt_i_d;
      rd_pipe_q <= rd_pipe_d;
    end
  end

  // Next state, memory request and fill bookkeeping.
  always_comb begin
    state_d          = state_q;
    req_cnt_d        = req_cnt_q;
    rx_cnt_d         = rx_cnt_q;
    blk_d            = blk_q;
    tgt_i_d          = tgt_i_q;
    mem.mem_enable   = 1'b0;
    mem.mem_wr       = 1'b0;
    mem.mem_addr     = '0;
    mem.mem_data_out = '0;

    rd_issue_c = (state_q == S_REQ);
    rd_pipe_d  = MEM_LAT'({rd_pipe_q, rd_issue_c});
    accept_c   = mem.mem_data_valid && rd_pipe_q[MEM_LAT-1] &&
                 ((state_q == S_REQ) || (state_q == S_DRAIN));
    last_c     = accept_c && (rx_cnt_q == LAST_IDX);

    // The miss being retired is still held high during its tag-write cycle.
    d_miss_ok_c = d_miss_i && !(last_c && !tgt_i_q);
    i_miss_ok_c = i_miss_i && !(last_c && tgt_i_q);
    dispatch_c  = (state_q == S_IDLE) || last_c;

    unique case (state_q)
      S_WRITE: begin
        mem.mem_enable   = 1'b1;
        mem.mem_wr       = 1'b1;
        mem.mem_addr     = d_wr_addr_i;
        mem.mem_data_out = d_wr_data_i;
        state_d          = S_IDLE;
      end
      S_REQ: begin
        mem.mem_enable = 1'b1;
        mem.mem_addr   = blk_q + ADDR_W'({req_cnt_q, 1'b0});
        req_cnt_d      = req_cnt_q + IDX_W'(1);
        if (req_cnt_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end
      end
      default: ;
    endcase

    if (accept_c) begin
      rx_cnt_d = rx_cnt_q + IDX_W'(1);
    end

    // Arbitration: the memory stage is older, so stores and D misses win.
    if (dispatch_c) begin
      state_d = S_IDLE;
      if (d_write_i) begin
        state_d = S_WRITE;
      end else if (d_miss_ok_c) begin
        state_d   = S_REQ;
        blk_d     = d_miss_addr_i & BLK_MASK;
        tgt_i_d   = 1'b0;
        req_cnt_d = '0;
        rx_cnt_d  = '0;
      end else if (i_miss_ok_c) begin
        state_d   = S_REQ;
        blk_d     = i_miss_addr_i & BLK_MASK;
        tgt_i_d   = 1'b1;
        req_cnt_d = '0;
        rx_cnt_d  = '0;
      end
    end
  end

  assign fill_data_o     = mem.mem_data_in;
  assign fill_word_idx_o = rx_cnt_q;
  assign fill_blk_addr_o = blk_q;
  assign i_fill_we_o     = accept_c && tgt_i_q;
  assign d_fill_we_o     = accept_c && !tgt_i_q;
  assign i_tag_we_o      = last_c && tgt_i_q;
  assign d_tag_we_o      = last_c && !tgt_i_q;
  assign i_stall_o       = i_miss_i;
  assign d_stall_o       = d_miss_i || (d_write_i && (state_q != S_WRITE));

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl with a fixed-latency pipelined memory model.
module tb_cache_fill_ctrl;

  logic        clk;
  logic        rst_n;
  logic        i_miss, d_miss, d_write;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        i_fill_we, d_fill_we, i_tag_we, d_tag_we, i_stall, d_stall;
  logic [2:0]  fill_word_idx;
  logic [15:0] fill_data, fill_blk_addr;

  int n_chk = 0;
  int n_bad = 0;

  cache_fill_ctrl_if #(.ADDR_W(16), .DATA_W(16)) mif ();

  cache_fill_ctrl #(.WORDS(8), .MEM_LAT(4), .ADDR_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_miss_i        (i_miss),
    .i_miss_addr_i   (i_miss_addr),
    .d_miss_i        (d_miss),
    .d_miss_addr_i   (d_miss_addr),
    .d_write_i       (d_write),
    .d_wr_addr_i     (d_wr_addr),
    .d_wr_data_i     (d_wr_data),
    .mem             (mif),
    .i_fill_we_o     (i_fill_we),
    .d_fill_we_o     (d_fill_we),
    .fill_word_idx_o (fill_word_idx),
    .fill_data_o     (fill_data),
    .fill_blk_addr_o (fill_blk_addr),
    .i_tag_we_o      (i_tag_we),
    .d_tag_we_o      (d_tag_we),
    .i_stall_o       (i_stall),
    .d_stall_o       (d_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: read at cycle c returns addr^0x5A5A during cycle c+4; ignores reset.
  logic [3:0]  pv = '0;
  logic [15:0] pa [4] = '{default: 16'h0};
  always @(posedge clk) begin
    pv    <= {pv[2:0], mif.mem_enable & ~mif.mem_wr};
    pa[0] <= mif.mem_addr;
    for (int i = 3; i > 0; i--) pa[i] <= pa[i-1];
  end
  assign mif.mem_data_valid = pv[3];
  assign mif.mem_data_in    = pv[3] ? (pa[3] ^ 16'h5A5A) : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks relative cycles k_first..k_last of a fill whose miss was seen at k=0.
  task automatic expect_fill(input logic tgt_i, input logic [15:0] base,
                             input int k_first, input int k_last, input int drop_k);
    logic [15:0] a;
    logic        en, we;
    for (int k = k_first; k <= k_last; k++) begin
      if (k == drop_k) begin
        if (tgt_i) i_miss = 1'b0; else d_miss = 1'b0;
      end
      @(negedge clk);
      en = (k >= 1) && (k <= 8);
      we = (k >= 5) && (k <= 12);
      chk("mem_en", 32'(mif.mem_enable), 32'(en));
      if (en) begin
        a = base + 16'(2 * (k - 1));
        chk("mem_wr", 32'(mif.mem_wr), 0);
        chk("mem_addr", 32'(mif.mem_addr), 32'(a));
      end
      chk("fill_we", 32'(tgt_i ? i_fill_we : d_fill_we), 32'(we));
      chk("fill_we_other", 32'(tgt_i ? d_fill_we : i_fill_we), 0);
      if (we) begin
        a = base + 16'(2 * (k - 5));
        chk("fill_idx", 32'(fill_word_idx), 32'(k - 5));
        chk("fill_data", 32'(fill_data), 32'(a ^ 16'h5A5A));
      end
      chk("tag_we", 32'(tgt_i ? i_tag_we : d_tag_we), 32'(k == 12));
      chk("tag_we_other", 32'(tgt_i ? d_tag_we : i_tag_we), 0);
      if (k == 12) chk("blk_addr", 32'(fill_blk_addr), 32'(base));
      chk("stall", 32'(tgt_i ? i_stall : d_stall), 32'(k < drop_k));
      step();
    end
    if (k_last == 12) begin
      if (tgt_i) i_miss = 1'b0; else d_miss = 1'b0;
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "_men"}, 32'(mif.mem_enable), 0);
    chk({tag, "_dstall"}, 32'(d_stall), 0);
    chk({tag, "_istall"}, 32'(i_stall), 0);
    chk({tag, "_fillwe"}, 32'(i_fill_we | d_fill_we), 0);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    i_miss = 1'b0; d_miss = 1'b0; d_write = 1'b0;
    i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    repeat (2) step();
    @(negedge clk);
    chk("rst_men", 32'(mif.mem_enable), 0);
    chk("rst_fillwe", 32'(i_fill_we | d_fill_we), 0);
    chk("rst_tagwe", 32'(i_tag_we | d_tag_we), 0);
    chk("rst_blk", 32'(fill_blk_addr), 0);
    chk("rst_idx", 32'(fill_word_idx), 0);
    chk("rst_stall", 32'(i_stall | d_stall), 0);
    step();
    rst_n = 1'b1;
    idle_check("post_rst");

    // 1: single D miss
    d_miss = 1'b1; d_miss_addr = 16'h1234;
    expect_fill(1'b0, 16'h1230, 0, 12, 99);
    idle_check("t1");

    // 2: simultaneous D and I miss, D first, I chained right after D tag write
    d_miss = 1'b1; d_miss_addr = 16'h0040;
    i_miss = 1'b1; i_miss_addr = 16'h0200;
    expect_fill(1'b0, 16'h0040, 0, 12, 99);
    expect_fill(1'b1, 16'h0200, 1, 12, 99);
    idle_check("t2");

    // 3: store with I miss pending
    d_write = 1'b1; d_wr_addr = 16'h0100; d_wr_data = 16'hBEEF;
    i_miss = 1'b1; i_miss_addr = 16'h1000;
    @(negedge clk);
    chk("t3_dstall_idle", 32'(d_stall), 1);
    chk("t3_men_idle", 32'(mif.mem_enable), 0);
    step();
    @(negedge clk);
    chk("t3_men", 32'(mif.mem_enable), 1);
    chk("t3_wr", 32'(mif.mem_wr), 1);
    chk("t3_addr", 32'(mif.mem_addr), 32'h0100);
    chk("t3_data", 32'(mif.mem_data_out), 32'hBEEF);
    chk("t3_dstall", 32'(d_stall), 0);
    chk("t3_istall", 32'(i_stall), 1);
    step();
    d_write = 1'b0;
    expect_fill(1'b1, 16'h1000, 0, 12, 99);
    idle_check("t3");

    // 4: top-of-memory block
    i_miss = 1'b1; i_miss_addr = 16'hFFFA;
    expect_fill(1'b1, 16'hFFF0, 0, 12, 99);
    idle_check("t4");

    // 5: reset in cycle 6 of a fill, then an immediate new miss
    d_miss = 1'b1; d_miss_addr = 16'h0500;
    expect_fill(1'b0, 16'h0500, 0, 5, 99);
    rst_n = 1'b0; d_miss = 1'b0;
    @(negedge clk);
    chk("t5_tag_rst", 32'(d_tag_we | i_tag_we), 0);
    step();
    rst_n = 1'b1; d_miss = 1'b1; d_miss_addr = 16'h0300;
    @(negedge clk);
    chk("t5_blk", 32'(fill_blk_addr), 0);
    chk("t5_men", 32'(mif.mem_enable), 0);
    chk("t5_late_we", 32'(d_fill_we | i_fill_we), 0);
    chk("t5_tag", 32'(d_tag_we | i_tag_we), 0);
    step();
    expect_fill(1'b0, 16'h0300, 1, 12, 99);
    idle_check("t5");

    // 6: I miss flushed at cycle 3; fill still completes
    i_miss = 1'b1; i_miss_addr = 16'h0A00;
    expect_fill(1'b1, 16'h0A00, 0, 12, 3);
    idle_check("t6");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
